// File: rtl/dlx_ctrl_pkg.sv
// Shared constants and types for the multi-cycle DLX controller:
// opcode/func encodings, ALU operation codes, FSM states and instruction classes.
package dlx_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LHI   = 6'h0F;
  localparam logic [5:0] OP_TRAP  = 6'h11;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h04;
  localparam logic [5:0] FN_SRL = 6'h06;
  localparam logic [5:0] FN_SRA = 6'h07;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;

  typedef enum logic [2:0] {
    START  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    ALU_R    = 4'd0,
    ALU_I    = 4'd1,
    LOAD     = 4'd2,
    STORE    = 4'd3,
    BRANCH   = 4'd4,
    JUMP     = 4'd5,
    JUMP_REG = 4'd6,
    TRAP     = 4'd7,
    ILLEGAL  = 4'd8
  } instr_class_t;

endpackage

// File: rtl/dlx_decode.sv
// Combinational instruction decoder: maps the latched opcode/func to an
// instruction class and the datapath operand/ALU selects.
module dlx_decode
  import dlx_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   func,
  output instr_class_t iclass,
  output logic [3:0]   alu_ctrl,
  output logic         ext_op,
  output logic         lhi_op,
  output logic         r_type
);

  always_comb begin
    iclass   = ILLEGAL;
    alu_ctrl = ALU_ADD;
    ext_op   = 1'b0;
    lhi_op   = 1'b0;
    r_type   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        iclass = ALU_R;
        r_type = 1'b1;
        case (func)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_XOR:  alu_ctrl = ALU_XOR;
          FN_SLL:  alu_ctrl = ALU_SLL;
          FN_SRL:  alu_ctrl = ALU_SRL;
          FN_SRA:  alu_ctrl = ALU_SRA;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: iclass   = ILLEGAL;
        endcase
      end
      OP_ADDI:  begin iclass = ALU_I; ext_op = 1'b1; alu_ctrl = ALU_ADD; end
      OP_ADDUI: begin iclass = ALU_I; alu_ctrl = ALU_ADD; end
      OP_SUBI:  begin iclass = ALU_I; ext_op = 1'b1; alu_ctrl = ALU_SUB; end
      OP_ANDI:  begin iclass = ALU_I; alu_ctrl = ALU_AND; end
      OP_ORI:   begin iclass = ALU_I; alu_ctrl = ALU_OR; end
      OP_XORI:  begin iclass = ALU_I; alu_ctrl = ALU_XOR; end
      // LHI shifts the zero-extended imm16 left by a constant 16.
      OP_LHI:   begin iclass = ALU_I; lhi_op = 1'b1; alu_ctrl = ALU_SLL; end
      OP_LW:    begin iclass = LOAD;  ext_op = 1'b1; alu_ctrl = ALU_ADD; end
      OP_SW:    begin iclass = STORE; ext_op = 1'b1; alu_ctrl = ALU_ADD; end
      OP_BEQZ, OP_BNEZ: begin iclass = BRANCH; ext_op = 1'b1; end
      OP_J, OP_JAL:     iclass = JUMP;
      OP_JR, OP_JALR:   iclass = JUMP_REG;
      OP_TRAP:          iclass = TRAP;
      default:          iclass = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle DLX sequencer: owns the IR copy and the FETCH/DECODE/EXEC/MEM/WB
// state machine, and drives every datapath and memory-port control strobe.
module multicycle_ctrl
  import dlx_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:WIDTH-1] instr,
  input  logic             mem_ready,
  input  logic             a_zero,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             ext_op,
  output logic             lhi_op,
  output logic             r_type,
  output logic [3:0]       alu_ctrl,
  output logic             branch,
  output logic             leap,
  output logic             reg_to_pc,
  output logic             link,
  output logic             halted,
  output logic [2:0]       dbg_state
);

  // Memory handshake: mem_req/mem_we/addr_sel are decoded from state only, so
  // they stay stable until the edge where mem_ready=1 completes the request;
  // mem_ready is only looked at in FETCH and MEM, where mem_req is high.

  state_t       state, state_nxt;
  logic [5:0]   ir_op, ir_func;
  instr_class_t iclass;
  logic [3:0]   dec_alu;
  logic         dec_ext, dec_lhi, dec_rt;
  logic         unused_instr_bits;

  // Only opcode and func steer control; register/immediate fields go straight to the datapath.
  assign unused_instr_bits = ^instr[6:25];
  assign dbg_state         = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= START;
      ir_op   <= 6'd0;
      ir_func <= 6'd0;
    end else begin
      state <= state_nxt;
      if (ir_we) begin
        ir_op   <= instr[0:5];
        ir_func <= instr[26:31];
      end
    end
  end

  dlx_decode u_decode (
    .opcode   (ir_op),
    .func     (ir_func),
    .iclass   (iclass),
    .alu_ctrl (dec_alu),
    .ext_op   (dec_ext),
    .lhi_op   (dec_lhi),
    .r_type   (dec_rt)
  );

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    ext_op     = 1'b0;
    lhi_op     = 1'b0;
    r_type     = 1'b0;
    alu_ctrl   = ALU_ADD;
    branch     = 1'b0;
    leap       = 1'b0;
    reg_to_pc  = 1'b0;
    link       = 1'b0;
    halted     = 1'b0;

    // Operand/ALU selects are held from EXEC through MEM and WB.
    if (state == EXEC || state == MEM || state == WB) begin
      ext_op   = dec_ext;
      lhi_op   = dec_lhi;
      r_type   = dec_rt;
      alu_ctrl = dec_alu;
    end

    case (state)
      START: state_nxt = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (iclass == TRAP || iclass == ILLEGAL) state_nxt = HALT;
        else                                     state_nxt = EXEC;
      end
      EXEC: begin
        case (iclass)
          BRANCH: begin
            branch    = 1'b1;
            pc_we     = (ir_op == OP_BEQZ) ? a_zero : !a_zero;
            state_nxt = FETCH;
          end
          JUMP: begin
            leap      = 1'b1;
            pc_we     = 1'b1;
            link      = (ir_op == OP_JAL);
            reg_we    = (ir_op == OP_JAL);
            state_nxt = FETCH;
          end
          JUMP_REG: begin
            reg_to_pc = 1'b1;
            pc_we     = 1'b1;
            link      = (ir_op == OP_JALR);
            reg_we    = (ir_op == OP_JALR);
            state_nxt = FETCH;
          end
          LOAD, STORE:  state_nxt = MEM;
          ALU_R, ALU_I: state_nxt = WB;
          default:      state_nxt = HALT;
        endcase
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (iclass == STORE);
        if (mem_ready) state_nxt = (iclass == STORE) ? FETCH : WB;
      end
      WB: begin
        reg_we     = 1'b1;
        mem_to_reg = (iclass == LOAD);
        state_nxt  = FETCH;
      end
      HALT: begin
        halted    = 1'b1;
        state_nxt = HALT;
      end
      default: state_nxt = START;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the 32-bit DLX datapath (pc_logic, register file, extenders, operand muxes, alu). It latches each instruction, decodes it, and steps the shared datapath and the single shared memory port through FETCH/DECODE/EXEC/MEM/WB. It also drives every datapath control strobe. It replaces the single-cycle combinational control so that instruction fetch and data access can share one memory port with wait states.

## Interface
Parameters:
- WIDTH, 32, datapath/instruction width; bit 0 is MSB, matching the datapath's [0:WIDTH-1] ordering.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- instr  input  WIDTH  memory read data, valid when mem_ready=1 in FETCH.
- mem_ready  input  1  memory completes the current request at this edge.
- a_zero  input  1  register A operand equals zero (from datapath).
- mem_req  output  1  memory request, held until completion.
- mem_we  output  1  request is a write (store).
- addr_sel  output  1  memory address source: 0=PC, 1=ALU result.
- ir_we, pc_we, reg_we  output  1 each  write enables for IR, PC and register file.
- mem_to_reg  output  1  register write data from memory (loads).
- ext_op  output  1  imm16 sign-extend (1) or zero-extend (0).
- lhi_op  output  1  LHI operand selection (A=zero-extended imm16, B=16).
- r_type  output  1  ALU B operand from register B.
- alu_ctrl  output  4  ALU operation.
- branch, leap, reg_to_pc, link  output  1 each  pc_logic target selects; link writes PC+4 to r31.
- halted  output  1  controller stopped on trap or illegal opcode.

## Operation
- States: START, FETCH, DECODE, EXEC, MEM, WB, HALT. Opcode is instr[0:5]; R-type func is instr[26:31].
- START: all outputs 0. Next state is FETCH.
- FETCH: mem_req=1, addr_sel=0, mem_we=0.
  - On mem_ready: ir_we=1 and pc_we=1 (PC+4), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: no strobes. TRAP (0x11) or an unlisted opcode/func goes to HALT; every other instruction goes to EXEC.
- EXEC: ext_op, lhi_op, r_type and alu_ctrl are driven from the IR. They hold constant through MEM and WB.
- Branches and jumps finish in EXEC, then go to FETCH:
  - BEQZ (0x04) asserts branch, and pc_we=a_zero.
  - BNEZ (0x05) asserts branch, and pc_we=!a_zero.
  - J (0x02) and JAL (0x03) assert leap and pc_we.
  - JR (0x12) and JALR (0x13) assert reg_to_pc and pc_we.
  - JAL and JALR also assert link and reg_we in the same cycle.
- Instructions that go on from EXEC:
  - LW (0x23) and SW (0x2B) go to MEM.
  - ALU ops go to WB.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for SW.
  - On mem_ready, SW goes to FETCH and LW goes to WB (the datapath latches load data at that edge).
  - Otherwise stay in MEM.
- WB: reg_we=1, mem_to_reg=1 for LW. Next state is FETCH.
- HALT: halted=1, every other output 0. Stays in HALT until reset.
- ext_op=1 for ADDI (0x08), SUBI (0x0A), LW, SW, BEQZ, BNEZ. ext_op=0 for ADDUI (0x09), ANDI (0x0C), ORI (0x0D), XORI (0x0E), LHI (0x0F).
- alu_ctrl codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8.
  - R-type func mapping: 0x20→ADD, 0x22→SUB, 0x24→AND, 0x25→OR, 0x26→XOR, 0x04→SLL, 0x06→SRL, 0x07→SRA, 0x2A→SLT.
  - LHI uses SLL with lhi_op=1.
  - LW and SW use ADD.

## Timing
- Reset asserted: state=START and all outputs 0 immediately (asynchronous). halted clears.
- Reset mid-transaction abandons any in-flight request; the memory must tolerate a dropped mem_req.
- Minimum cycles per instruction, excluding START:
  - Branches and jumps: 3.
  - ALU ops and SW: 4.
  - LW: 5.
  - Each memory wait cycle adds 1.
- Outputs are Moore (decoded from state and IR), except ir_we, pc_we in FETCH, and the MEM exit, which are qualified by mem_ready in the same cycle.
- mem_req, mem_we and addr_sel stay stable from assertion until the mem_ready edge. mem_ready is ignored while mem_req=0.
- Taken branch/jump: pc_we for the target fires at the EXEC edge. The FETCH-time PC+4 has already occurred.

## Structure
- Package dlx_ctrl_pkg holds:
  - opcode and func constants;
  - alu_ctrl codes;
  - the state enum;
  - an instruction-class enum: ALU_R, ALU_I, LOAD, STORE, BRANCH, JUMP, JUMP_REG, TRAP, ILLEGAL.
- Sub-module dlx_decode is combinational. It maps IR to instruction class, alu_ctrl, ext_op, lhi_op and r_type.
- The FSM and the IR copy live in multicycle_ctrl.

## Test plan
- Reset release, then ADD r3,r1,r2 (R-type, func 0x20) with mem_ready=1: FETCH→DECODE→EXEC→WB. alu_ctrl=0 and r_type=1 in EXEC/WB; reg_we=1 only in the WB cycle; 4 cycles total.
- LW with 2 wait cycles in FETCH and 1 in MEM: mem_req held steady; ir_we is a single pulse; mem_to_reg=1 in WB; 8 cycles total.
- BEQZ with a_zero=1: pc_we=1 and branch=1 in EXEC. Repeat with a_zero=0: branch=1, pc_we=0 in EXEC. Both return to FETCH in 3 cycles.
- JAL: leap, link, reg_we and pc_we all high in the single EXEC cycle, then FETCH.
- LHI 0x1234: lhi_op=1, ext_op=0, alu_ctrl=5.
- Opcode 0x3F: HALT, halted=1 held indefinitely.
- Reset pulse during MEM of SW: mem_req drops with no clock edge; START follows reset release.
